// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module      : data_mem_responder
//  Description : Word-organised data memory behind a valid/ready request
//                channel and a valid/ready response channel. Each accepted
//                request is held for WAIT_CYCLES wait states. The memory
//                operation happens on the edge that enters the response state.
//                The response is then held until the initiator takes it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH_WORDS : number of 32-bit words (power of two, 4..4096)
//    WAIT_CYCLES : wait states before each response (0..15)
//  Ports
//    clock       : single rising-edge clock
//    reset       : asynchronous active-low reset
//    req_valid   : request present            req_ready  : request accepted
//    req_write   : 1 = store, 0 = load        endereco   : byte address
//    write_data  : store data                 byte_en    : store byte lanes
//    resp_valid  : response present           resp_ready : response taken
//    read_data   : load data (0 for stores)   erro       : access error
//  Build option
//    DMEM_RESP_ERR_CHECK_EN : when defined, misaligned or out-of-range
//                             accesses report erro=1 and do not touch memory.
//                             When undefined, the address wraps and erro is 0.
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] endereco,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_en,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] read_data,
    output logic        erro
);

    localparam int         c_addr_w = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait   = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_count;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [31:0]           r_read_data;
    logic                  r_erro;

    // Transaction captured at the accept edge
    logic                  r_write;
    logic [c_addr_w-1:0]   r_idx;
    logic [31:0]           r_data;
    logic [3:0]            r_be;
    logic                  r_err;

    logic [31:0]           r_mem [DEPTH_WORDS];

    logic                  w_accept;
    logic [c_addr_w-1:0]   w_idx_in;
    logic                  w_err_in;
    logic                  w_enter_resp;
    logic                  w_op_write;
    logic [c_addr_w-1:0]   w_op_idx;
    logic [31:0]           w_op_data;
    logic [3:0]            w_op_be;
    logic                  w_op_err;
    logic                  w_mem_we;
    logic [31:0]           w_load_word;

    assign w_accept = req_valid && r_req_ready;
    assign w_idx_in = endereco[c_addr_w+1:2];

`ifdef DMEM_RESP_ERR_CHECK_EN
    localparam logic [31:0] c_byte_limit = 32'(4 * DEPTH_WORDS);

    assign w_err_in = (endereco[1:0] != 2'b00) || (endereco >= c_byte_limit);
`else
    // Byte offset and bits above the word index are ignored, so the
    // address wraps modulo DEPTH_WORDS.
    logic w_unused_addr;

    assign w_unused_addr = ^{endereco[31:c_addr_w+2], endereco[1:0]};
    assign w_err_in      = 1'b0;
`endif

    // RESP is entered straight from IDLE only when there are no wait states.
    // In that case the operation must use the live request inputs, because
    // the latched copy is written on that same edge.
    assign w_enter_resp = ((r_state == IDLE) && w_accept && (c_wait == 4'd0)) ||
                          ((r_state == WAIT) && (r_count == 4'd1));

    assign w_op_write = (r_state == IDLE) ? req_write  : r_write;
    assign w_op_idx   = (r_state == IDLE) ? w_idx_in   : r_idx;
    assign w_op_data  = (r_state == IDLE) ? write_data : r_data;
    assign w_op_be    = (r_state == IDLE) ? byte_en    : r_be;
    assign w_op_err   = (r_state == IDLE) ? w_err_in   : r_err;

    assign w_mem_we    = w_enter_resp && w_op_write && !w_op_err;
    assign w_load_word = r_mem[w_op_idx];

    // Storage has no reset, so its contents survive reset. A write can only
    // happen from WAIT, or from IDLE with req_ready high. Reset clears both
    // conditions, so an aborted store is never performed.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    r_mem[w_op_idx][8*i +: 8] <= w_op_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_count      <= 4'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_read_data  <= 32'd0;
            r_erro       <= 1'b0;
            r_write      <= 1'b0;
            r_idx        <= '0;
            r_data       <= 32'd0;
            r_be         <= 4'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Ready rises in the first cycle after reset and stays
                    // high until a request is taken.
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_write     <= req_write;
                        r_idx       <= w_idx_in;
                        r_data      <= write_data;
                        r_be        <= byte_en;
                        r_err       <= w_err_in;
                        if (c_wait == 4'd0) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_count <= c_wait;
                        end
                    end
                end
                WAIT: begin
                    if (r_count == 4'd1) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_count      <= 4'd0;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                RESP: begin
                    // Ready is raised only on the following edge, so a
                    // response never overlaps a new accept in one cycle.
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b0;
                end
            endcase

            if (w_enter_resp) begin
                r_read_data <= (w_op_write || w_op_err) ? 32'd0 : w_load_word;
                r_erro      <= w_op_err;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign read_data  = r_read_data;
    assign erro       = r_erro;

endmodule

`default_nettype wire
